// File: rtl/conv33_pkg.sv
// rtl/conv33_pkg.sv - shared defaults and pixel type for the 3x3 output collector
package conv33_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_IMG_W = 64;
  localparam int DEF_IMG_H = 64;

  typedef logic [DEF_WIDTH-1:0] pixel_t;
endpackage

// File: rtl/collector_fifo.sv
// rtl/collector_fifo.sv - result FIFO with a registered head word and valid
module collector_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             push_acc;
  logic             pop_acc;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_acc  = pop && !empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_acc = push && (!full || pop_acc);
  assign rd_next  = pop_acc ? rd_ptr + 1'b1 : rd_ptr;

  always_comb begin
    count_next = count;
    if (push_acc && !pop_acc)
      count_next = count + 1'b1;
    else if (!push_acc && pop_acc)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_acc)
      mem[wr_ptr] <= din;
  end

  // The head register tracks the entry at the next read pointer, bypassing
  // the array when that entry is the one being written this cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      if (push_acc)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr     <= rd_next;
      count      <= count_next;
      head_valid <= (count_next != '0);
      if (count_next != '0)
        head_data <= (push_acc && (wr_ptr == rd_next)) ? din : mem[rd_next];
    end
  end
endmodule

// File: rtl/conv33_output_collector.sv
// rtl/conv33_output_collector.sv - masks 3x3 warm-up samples and queues window results; option CONV33_COLLECTOR_OVF_COUNT_EN
module conv33_output_collector
  import conv33_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             frame_done,
  output logic             overflow
`ifdef CONV33_COLLECTOR_OVF_COUNT_EN
  ,
  output logic [15:0]      ovf_count
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_last;
  logic          row_last;
  logic          sample_ok;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          drop;

  assign col_last  = (col == CW'(IMG_W - 1));
  assign row_last  = (row == RW'(IMG_H - 1));
  // The first two rows and columns belong to line-buffer and window warm-up.
  assign sample_ok = in_valid && (row >= RW'(2)) && (col >= CW'(2));
  assign pop       = !fifo_empty && out_ready;
  assign drop      = sample_ok && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= in_valid && col_last && row_last;
      if (drop)
        overflow <= 1'b1;
      if (in_valid) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

`ifdef CONV33_COLLECTOR_OVF_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset)
      ovf_count <= '0;
    else if (drop && (ovf_count != 16'hFFFF))
      ovf_count <= ovf_count + 16'd1;
  end
`endif

  collector_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (sample_ok),
    .din        (in_data),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_valid (out_valid),
    .head_data  (out_data)
  );
endmodule

// File: tb/tb_conv33_output_collector.sv
// tb/tb_conv33_output_collector.sv - scoreboard bench for conv33_output_collector
module tb_conv33_output_collector;
  localparam int W = 4;
  localparam int H = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;
  logic        frame_done;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  int occ = 0;
  int idx = 0;
  bit ovf_exp = 0;

  always #5 clk = ~clk;

  conv33_output_collector #(
    .WIDTH      (16),
    .IMG_W      (W),
    .IMG_H      (H),
    .FIFO_DEPTH (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference: raster index -> (row, col); a result exists when both are >= 2.
  // Occupancy model decides whether a result is queued or dropped.
  task automatic step(input bit iv, input logic [15:0] d, input bit rdy);
    bit pop;
    bit vs;
    bit fd;
    int r;
    int c;
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    pop = (occ > 0) && rdy;
    r = idx / W;
    c = idx % W;
    vs = iv && (r >= 2) && (c >= 2);
    fd = iv && (idx == W * H - 1);
    if (vs) begin
      if (occ < D || pop) begin
        exp_q.push_back(d);
        occ++;
      end else begin
        ovf_exp = 1;
      end
    end
    if (pop) occ--;
    if (iv) idx = (idx + 1) % (W * H);
    @(posedge clk);
    #1;
    check("out_valid", int'(out_valid), int'(occ > 0));
    check("frame_done", int'(frame_done), int'(fd));
    check("overflow", int'(overflow), int'(ovf_exp));
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    occ = 0;
    idx = 0;
    ovf_exp = 0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_overflow", int'(overflow), 0);
  endtask

  task automatic frame_seq(input bit rdy);
    for (int i = 0; i < W * H; i++) step(1'b1, 16'(i), rdy);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b1);
  endtask

  // Monitor: pops the scoreboard on every transfer and checks head stability.
  initial begin
    logic [15:0] want;
    logic [15:0] hold_data;
    bit hold_pend;
    hold_pend = 0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (reset && hold_pend && out_valid)
        check("hold_stable", int'(out_data), int'(hold_data));
      if (reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", int'(out_data), -1);
        end else begin
          want = exp_q.pop_front();
          check("out_data", int'(out_data), int'(want));
        end
      end
      hold_pend = reset && out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    frame_seq(1'b1);
    drain(3);

    do_reset();
    frame_seq(1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0);
    drain(6);

    do_reset();
    frame_seq(1'b0);
    frame_seq(1'b0);
    drain(6);

    do_reset();
    frame_seq(1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 16'(i), 1'b0);
    step(1'b1, 16'd10, 1'b1);
    for (int i = 11; i < 16; i++) step(1'b1, 16'(i), 1'b1);
    drain(6);

    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 16'(100 + i), 1'b1);
    do_reset();
    frame_seq(1'b1);
    drain(3);

    do_reset();
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, 16'(i), 1'b1);
      step(1'b0, 16'hdead, 1'b1);
      step(1'b0, 16'hbeef, 1'b1);
    end
    drain(3);

    do_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, 16'($urandom_range(0, 65535)), $urandom_range(0, 1) == 1);
    drain(8);

    check("scoreboard_empty", exp_q.size(), 0);
    check("final_out_valid", int'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
